bus_bridge: RTL
===============

// Module: bus_bridge
// PURPOSE
//  Parametrised CPU-to-memory bus bridge: accepts one 32-bit word request via req/ack handshake.
//  Decodes addr[31:20] to one of three regions: IRAM, DRAM, VGA.
//  Splits the word into 32/MEM_DW narrow beats on a shared memory port, low beat first.
//  Reassembles read data. Sits between the core's load/store unit and the SRAM/VGA drivers.
// PARAMETERS
//  MEM_DW       16      memory beat width; legal 8, 16, 32 (NBEATS = 32/MEM_DW, BEAT_W = max(1, log2 NBEATS))
//  IRAM_BASE    12'h000 addr[31:20] tag for region 0 (IRAM)
//  DRAM_BASE    12'h001 addr[31:20] tag for region 1 (DRAM)
//  VGA_BASE     12'h002 addr[31:20] tag for region 2 (VGA)
//  TIMEOUT_CYC  255     stall limit per beat; used only with BUS_TIMEOUT_EN
// PORTS
//  sck      in   1           clock, all logic on rising edge
//  rst_n    in   1           synchronous reset, active-low
//  req      in   1           request; held high by the master until ack
//  rw       in   1           1 = write, 0 = read
//  addr     in   32          byte address; addr[1:0] ignored (word aligned)
//  wdata    in   32          write word
//  rdata    out  32          read word, valid while ack=1, held until next accepted req
//  ack      out  1           one-cycle completion pulse
//  err      out  1           qualifies ack: unmapped address or timeout
//  m_cs_n   out  3           per-region chip select, active-low, one-hot-low
//  m_rw     out  1           beat direction
//  m_addr   out  18+BEAT_W   {addr[19:2], beat index}
//  m_wdata  out  MEM_DW      wdata[beat*MEM_DW +: MEM_DW]
//  m_rdata  in   MEM_DW      beat read data
//  m_ready  in   1           driver completes the current beat this cycle
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//   - state=IDLE, beat=0, ack=0, err=0, rdata=0.
//   - m_cs_n=3'b111, m_rw=0, m_addr=0, m_wdata=0.
//   - Reset mid-transaction aborts it: no ack, and no further beats are issued.
//  FSM IDLE -> BEAT -> DONE -> IDLE:
//   - IDLE: when req=1, latch rw, addr and wdata, then decode.
//     - Tag matches a region: go to BEAT with beat=0, and clear rdata.
//     - No tag match: go to DONE with err=1; no m_cs_n asserted.
//   - BEAT: m_cs_n[region]=0; m_rw, m_addr and m_wdata are driven from the latched request.
//     - On m_ready=1, read data is captured: rdata[beat*MEM_DW +: MEM_DW] <= m_rdata. On writes, m_rdata is ignored.
//     - The beat then advances; after beat NBEATS-1, go to DONE with err=0.
//     - On m_ready=0, all outputs hold.
//   - DONE: ack=1 for exactly one cycle, err as set, then IDLE. m_cs_n=3'b111.
//  Handshake:
//   - req is sampled only in IDLE. A request still high during DONE is not re-accepted until the IDLE cycle after DONE.
//   - Minimum spacing between accepted requests is NBEATS+2 cycles.
//   - Changing addr, wdata or rw while busy has no effect on the transfer (latched copies are used).
//  Latency: with m_ready tied 1, ack is high in the cycle after NBEATS+1 edges following the accepting edge.
//   - MEM_DW=16: 3 cycles. Unmapped: 1 cycle.
//  Outputs m_* are decoded combinationally from registered state; no combinational path from req to m_*.
//  Overlapping region tags (parameter misconfiguration): the lowest region index wins.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//   - A per-beat counter clears on entry to each beat and on m_ready.
//   - After TIMEOUT_CYC consecutive BEAT cycles with m_ready=0: abort, rdata=0, go to DONE with err=1.
//  BUS_TIMEOUT_EN undefined:
//   - No counter; BEAT waits on m_ready indefinitely; TIMEOUT_CYC is unused.
// TESTING
//  1. DRAM write, MEM_DW=16, m_ready=1: req addr=0x0010_0008, wdata=0xDEADBEEF
//     -> m_cs_n=3'b101; beat0 m_addr=0x00004, m_wdata=0xBEEF; beat1 m_addr=0x00005, m_wdata=0xDEAD;
//     -> ack=1, err=0 in the 3rd cycle.
//  2. IRAM read, m_ready low 2 cycles on beat0, m_rdata 0x5678 then 0x1234
//     -> m_cs_n=3'b110; ack after 5 cycles; rdata=0x12345678.
//  3. Unmapped req addr=0x0030_0000 -> m_cs_n stays 3'b111; ack=1, err=1 one cycle later; rdata=0.
//  4. rst_n=0 during beat1 of a DRAM write -> next cycle m_cs_n=3'b111, ack=0, state IDLE;
//     a fresh req then completes normally.
//  5. MEM_DW=8 VGA read, m_rdata 0x11,0x22,0x33,0x44 -> four beats, beat index 0..3; rdata=0x44332211.
//  6. BUS_TIMEOUT_EN, TIMEOUT_CYC=4, m_ready=0 -> ack=1, err=1 after 4 stall cycles.
//     Without the macro, no ack after 1000 cycles.

Source files
------------

// File: rtl/bus_bridge.sv
// -----------------------------------------------------------------------------
// bus_bridge
//   Bridges one 32-bit CPU word request (req/ack handshake) onto a narrow,
//   shared memory port. addr[31:20] selects IRAM, DRAM or VGA. The word is
//   moved as 32/MEM_DW beats, low beat first, and read beats are reassembled
//   into rdata_o.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   When defined, a beat stalled for TIMEOUT_CYC consecutive cycles aborts the
//   transfer with err_o=1. When undefined, a beat waits on m_ready_i forever.
//
// Ports
//   sck_i       clock, rising edge
//   rst_n_i     synchronous reset, active low
//   req_i       request, held by the master until ack_o
//   rw_i        1 = write, 0 = read
//   addr_i      byte address (bits 1:0 ignored)
//   wdata_i     write word
//   rdata_o     read word, valid with ack_o, held until the next accepted req
//   ack_o       one-cycle completion pulse
//   err_o       qualifies ack_o: unmapped address or timeout
//   m_cs_n_o    per-region chip select, active low
//   m_rw_o      beat direction
//   m_addr_o    {addr[19:2], beat index}
//   m_wdata_o   current write beat
//   m_rdata_i   read beat data
//   m_ready_i   memory completes the current beat this cycle
// -----------------------------------------------------------------------------
module bus_bridge #(
  parameter int          MEM_DW      = 16,
  parameter logic [11:0] IRAM_BASE   = 12'h000,
  parameter logic [11:0] DRAM_BASE   = 12'h001,
  parameter logic [11:0] VGA_BASE    = 12'h002,
  parameter int          TIMEOUT_CYC = 255,
  localparam int         NBEATS      = 32 / MEM_DW,
  localparam int         BEAT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic              sck_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              rw_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic              err_o,
  output logic [2:0]        m_cs_n_o,
  output logic              m_rw_o,
  output logic [18+BEAT_W-1:0] m_addr_o,
  output logic [MEM_DW-1:0] m_wdata_o,
  input  logic [MEM_DW-1:0] m_rdata_i,
  input  logic              m_ready_i
);

  if (!(MEM_DW == 8 || MEM_DW == 16 || MEM_DW == 32) || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("bus_bridge: MEM_DW must be 8, 16 or 32 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  state_t                         state_q, state_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic                           rw_q, rw_d;
  logic [17:0]                    addr_q, addr_d;
  logic [31:0]                    wdata_q, wdata_d;
  logic [1:0]                     region_q, region_d;
  logic [NBEATS-1:0][MEM_DW-1:0]  rdata_q, rdata_d;
  logic                           err_q, err_d;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Only addr[31:20] (decode) and addr[19:2] (latched) matter.
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

  // Region decode; on overlapping tags the lowest region index wins.
  logic       hit;
  logic [1:0] hit_idx;
  always_comb begin
    hit     = 1'b1;
    hit_idx = 2'd0;
    if      (addr_i[31:20] == IRAM_BASE) hit_idx = 2'd0;
    else if (addr_i[31:20] == DRAM_BASE) hit_idx = 2'd1;
    else if (addr_i[31:20] == VGA_BASE)  hit_idx = 2'd2;
    else                                 hit     = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    region_d = region_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          rw_d    = rw_i;
          addr_d  = addr_i[19:2];
          wdata_d = wdata_i;
          beat_d  = '0;
          rdata_d = '0;
`ifdef BUS_TIMEOUT_EN
          tmo_d   = '0;
`endif
          if (hit) begin
            region_d = hit_idx;
            err_d    = 1'b0;
            state_d  = S_BEAT;
          end else begin
            err_d    = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_BEAT: begin
        if (m_ready_i) begin
          if (!rw_q) rdata_d[beat_q] = m_rdata_i;
`ifdef BUS_TIMEOUT_EN
          tmo_d = '0;
`endif
          if (beat_q == LAST_BEAT) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
`ifdef BUS_TIMEOUT_EN
        // tmo_q counts stall cycles already seen; this is the last allowed one.
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        beat_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sck_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      region_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      region_q <= region_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  // Memory side is decoded from registered state only.
  logic [NBEATS-1:0][MEM_DW-1:0] wbeats;
  assign wbeats = wdata_q;

  always_comb begin
    m_cs_n_o  = 3'b111;
    m_rw_o    = 1'b0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    if (state_q == S_BEAT) begin
      case (region_q)
        2'd0:    m_cs_n_o = 3'b110;
        2'd1:    m_cs_n_o = 3'b101;
        2'd2:    m_cs_n_o = 3'b011;
        default: m_cs_n_o = 3'b111;
      endcase
      m_rw_o    = rw_q;
      m_addr_o  = {addr_q, beat_q};
      m_wdata_o = wbeats[beat_q];
    end
  end

  assign ack_o   = (state_q == S_DONE);
  assign err_o   = (state_q == S_DONE) && err_q;
  assign rdata_o = rdata_q;

endmodule
